// File: rtl/inst_fetch_buffer.sv
// ---------------------------------------------------------------------------
// inst_fetch_buffer
//
// Purpose: instruction queue between the fetch stage and the decoders.
// Fetch can write up to two entries per cycle. Decode sees the two oldest
// entries with no added latency (first-word-fall-through) and may consume
// up to two entries per cycle. A flush empties the queue.
//
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   flush               discard all contents; takes priority over read/write
//   fetch_valid[1:0]    per-slot write valid (00, 01, 11)
//   fetch_pc/inst/is_exc/exc_cause{0,1}   write data for slot 0 / slot 1
//   fetch_ready         queue can take a write pair this cycle
//   dec_valid[1:0]      head / head+1 entry valid
//   dec_pc/inst/is_exc/exc_cause{0,1}     head / head+1 entry contents
//   dec_accept[1:0]     entries consumed by decode (00, 01, 11)
//   count               current occupancy
// ---------------------------------------------------------------------------
module inst_fetch_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [1:0]       fetch_valid,
    input  logic [31:0]      fetch_pc0,
    input  logic [31:0]      fetch_pc1,
    input  logic [31:0]      fetch_inst0,
    input  logic [31:0]      fetch_inst1,
    input  logic             fetch_is_exc0,
    input  logic             fetch_is_exc1,
    input  logic [6:0]       fetch_exc_cause0,
    input  logic [6:0]       fetch_exc_cause1,
    output logic             fetch_ready,
    output logic [1:0]       dec_valid,
    output logic [31:0]      dec_pc0,
    output logic [31:0]      dec_pc1,
    output logic [31:0]      dec_inst0,
    output logic [31:0]      dec_inst1,
    output logic             dec_is_exc0,
    output logic             dec_is_exc1,
    output logic [6:0]       dec_exc_cause0,
    output logic [6:0]       dec_exc_cause1,
    input  logic [1:0]       dec_accept,
    output logic [PTR_W:0]   count
);

    // A pair write needs two free slots, so the last legal occupancy for
    // accepting a write is DEPTH-2.
    localparam logic [PTR_W:0] LP_READY_MAX = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0] LP_TWO       = (PTR_W+1)'(2);

    logic [31:0]      r_pc    [DEPTH];
    logic [31:0]      r_inst  [DEPTH];
    logic             r_exc   [DEPTH];
    logic [6:0]       r_cause [DEPTH];

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_cnt;

    logic [PTR_W-1:0] w_rd_ptr1;
    logic [PTR_W-1:0] w_wr_ptr1;
    logic             w_wr_en;
    logic [1:0]       w_acc;
    logic [1:0]       w_n_wr;
    logic [1:0]       w_n_rd;

    // DEPTH is a power of two, so natural PTR_W-bit overflow is the wrap.
    assign w_rd_ptr1 = r_rd_ptr + 1'b1;
    assign w_wr_ptr1 = r_wr_ptr + 1'b1;

    // Ready looks only at registered occupancy; same-cycle reads do not help.
    assign fetch_ready = (r_cnt <= LP_READY_MAX) && !flush;
    assign w_wr_en     = fetch_ready;

    assign dec_valid = {(r_cnt >= LP_TWO), (r_cnt != '0)};

    assign dec_pc0        = r_pc[r_rd_ptr];
    assign dec_inst0      = r_inst[r_rd_ptr];
    assign dec_is_exc0    = r_exc[r_rd_ptr];
    assign dec_exc_cause0 = r_cause[r_rd_ptr];
    assign dec_pc1        = r_pc[w_rd_ptr1];
    assign dec_inst1      = r_inst[w_rd_ptr1];
    assign dec_is_exc1    = r_exc[w_rd_ptr1];
    assign dec_exc_cause1 = r_cause[w_rd_ptr1];

    assign count = r_cnt;

    // Accept bits on slots that hold nothing are ignored; 10 is not a
    // contiguous consume and counts as zero.
    assign w_acc = dec_accept & dec_valid;

    always_comb begin
        w_n_wr = 2'd0;
        if (w_wr_en) begin
            case (fetch_valid)
                2'b01:   w_n_wr = 2'd1;
                2'b11:   w_n_wr = 2'd2;
                default: w_n_wr = 2'd0;
            endcase
        end
    end

    always_comb begin
        w_n_rd = 2'd0;
        case (w_acc)
            2'b01:   w_n_rd = 2'd1;
            2'b11:   w_n_rd = 2'd2;
            default: w_n_rd = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_n_rd);
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_wr);
            r_cnt    <= r_cnt + (PTR_W+1)'(w_n_wr) - (PTR_W+1)'(w_n_rd);
        end
    end

    // Storage is not cleared by flush; only the pointers move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_inst[i]  <= '0;
                r_exc[i]   <= 1'b0;
                r_cause[i] <= '0;
            end
        end else begin
            if (w_wr_en && fetch_valid[0]) begin
                r_pc[r_wr_ptr]    <= fetch_pc0;
                r_inst[r_wr_ptr]  <= fetch_inst0;
                r_exc[r_wr_ptr]   <= fetch_is_exc0;
                r_cause[r_wr_ptr] <= fetch_exc_cause0;
            end
            if (w_wr_en && (fetch_valid == 2'b11)) begin
                r_pc[w_wr_ptr1]    <= fetch_pc1;
                r_inst[w_wr_ptr1]  <= fetch_inst1;
                r_exc[w_wr_ptr1]   <= fetch_is_exc1;
                r_cause[w_wr_ptr1] <= fetch_exc_cause1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
module tb_inst_fetch_buffer;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    localparam int S_VALID = 0;
    localparam int S_READY = 1;
    localparam int S_COUNT = 2;
    localparam int S_PC0   = 3;
    localparam int S_PC1   = 4;
    localparam int S_INST0 = 5;
    localparam int S_INST1 = 6;
    localparam int S_EXC0  = 7;
    localparam int S_CAUSE0 = 8;
    localparam int S_EXC1  = 9;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [6:0]  cause;
    } ent_t;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  fetch_valid = 2'b00;
    logic [31:0] fetch_pc0 = '0, fetch_pc1 = '0, fetch_inst0 = '0, fetch_inst1 = '0;
    logic        fetch_is_exc0 = 1'b0, fetch_is_exc1 = 1'b0;
    logic [6:0]  fetch_exc_cause0 = '0, fetch_exc_cause1 = '0;
    logic [1:0]  dec_accept = 2'b00;
    logic        fetch_ready;
    logic [1:0]  dec_valid;
    logic [31:0] dec_pc0, dec_pc1, dec_inst0, dec_inst1;
    logic        dec_is_exc0, dec_is_exc1;
    logic [6:0]  dec_exc_cause0, dec_exc_cause1;
    logic [PTR_W:0] count;

    inst_fetch_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .fetch_valid(fetch_valid),
        .fetch_pc0(fetch_pc0), .fetch_pc1(fetch_pc1),
        .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1),
        .fetch_is_exc0(fetch_is_exc0), .fetch_is_exc1(fetch_is_exc1),
        .fetch_exc_cause0(fetch_exc_cause0), .fetch_exc_cause1(fetch_exc_cause1),
        .fetch_ready(fetch_ready), .dec_valid(dec_valid),
        .dec_pc0(dec_pc0), .dec_pc1(dec_pc1),
        .dec_inst0(dec_inst0), .dec_inst1(dec_inst1),
        .dec_is_exc0(dec_is_exc0), .dec_is_exc1(dec_is_exc1),
        .dec_exc_cause0(dec_exc_cause0), .dec_exc_cause1(dec_exc_cause1),
        .dec_accept(dec_accept), .count(count)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mcnt = 0;
    chk_t cq[$];
    ent_t mq[$];
    ent_t z = '{default: '0};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ent_t mk(logic [31:0] pc, logic [31:0] inst, logic exc, logic [6:0] cause);
        ent_t e;
        e.pc = pc; e.inst = inst; e.exc = exc; e.cause = cause;
        return e;
    endfunction

    function automatic logic [31:0] get(int sel);
        case (sel)
            S_VALID:  return {30'b0, dec_valid};
            S_READY:  return {31'b0, fetch_ready};
            S_COUNT:  return {28'b0, count};
            S_PC0:    return dec_pc0;
            S_PC1:    return dec_pc1;
            S_INST0:  return dec_inst0;
            S_INST1:  return dec_inst1;
            S_EXC0:   return {31'b0, dec_is_exc0};
            S_CAUSE0: return {25'b0, dec_exc_cause0};
            S_EXC1:   return {31'b0, dec_is_exc1};
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Expected status for the current cycle, checked at this cycle's negedge.
    task automatic ex(input int sel, input logic [31:0] val, input string name);
        chk_t c;
        c.cyc = cyc; c.sel = sel; c.val = val; c.name = name;
        cq.push_back(c);
    endtask

    // Monitor: status checks due this cycle, plus every entry the decoder
    // consumes is compared against the oldest expected entry.
    chk_t        mc;
    ent_t        me;
    logic [31:0] mgot;
    always @(negedge clk) begin
        while (cq.size() > 0 && cq[0].cyc <= cyc) begin
            mc = cq.pop_front();
            mgot = get(mc.sel);
            n_cmp++;
            if (mc.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: check missed its cycle (due %0d, now %0d)", mc.name, mc.cyc, cyc);
            end else if (mgot !== mc.val) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", mc.name, mgot, mc.val);
            end
        end
        if (rst_n && !flush) begin
            for (int s = 0; s < 2; s++) begin
                if ((s == 0 && (dec_accept & dec_valid) != 2'b00 && (dec_accept & dec_valid) != 2'b10) ||
                    (s == 1 && (dec_accept & dec_valid) == 2'b11)) begin
                    n_cmp++;
                    if (mq.size() == 0) begin
                        n_bad++;
                        $display("FAIL data slot%0d: consumed entry with none expected", s);
                    end else begin
                        me = mq.pop_front();
                        if (s == 0) mgot = dec_pc0; else mgot = dec_pc1;
                        if ((s == 0 && {dec_pc0, dec_inst0, dec_is_exc0, dec_exc_cause0} !== {me.pc, me.inst, me.exc, me.cause}) ||
                            (s == 1 && {dec_pc1, dec_inst1, dec_is_exc1, dec_exc_cause1} !== {me.pc, me.inst, me.exc, me.cause})) begin
                            n_bad++;
                            if (s == 0)
                                $display("FAIL data slot0: got pc=%h inst=%h exc=%b cause=%h expected pc=%h inst=%h exc=%b cause=%h",
                                         dec_pc0, dec_inst0, dec_is_exc0, dec_exc_cause0, me.pc, me.inst, me.exc, me.cause);
                            else
                                $display("FAIL data slot1: got pc=%h inst=%h exc=%b cause=%h expected pc=%h inst=%h exc=%b cause=%h",
                                         dec_pc1, dec_inst1, dec_is_exc1, dec_exc_cause1, me.pc, me.inst, me.exc, me.cause);
                        end
                    end
                end
            end
        end
    end

    // One cycle of stimulus: drive, record accepted writes, take the edge,
    // return to idle just after it.
    task automatic step(input logic [1:0] fv, input logic [1:0] acc, input ent_t e0, input ent_t e1);
        int nw, nr;
        logic [1:0] mv, ar;
        fetch_valid = fv;
        dec_accept = acc;
        fetch_pc0 = e0.pc; fetch_inst0 = e0.inst; fetch_is_exc0 = e0.exc; fetch_exc_cause0 = e0.cause;
        fetch_pc1 = e1.pc; fetch_inst1 = e1.inst; fetch_is_exc1 = e1.exc; fetch_exc_cause1 = e1.cause;
        nw = 0;
        if (mcnt <= DEPTH - 2) begin
            if (fv == 2'b01) begin nw = 1; mq.push_back(e0); end
            if (fv == 2'b11) begin nw = 2; mq.push_back(e0); mq.push_back(e1); end
        end
        mv = (mcnt >= 2) ? 2'b11 : (mcnt >= 1) ? 2'b01 : 2'b00;
        ar = acc & mv;
        nr = (ar == 2'b01) ? 1 : (ar == 2'b11) ? 2 : 0;
        mcnt = mcnt + nw - nr;
        @(posedge clk);
        #1;
        fetch_valid = 2'b00;
        dec_accept = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ex(S_VALID, 32'd0, "rst_valid");
        ex(S_READY, 32'd1, "rst_ready");
        ex(S_COUNT, 32'd0, "rst_count");
        ex(S_PC0, 32'd0, "rst_pc0");
        ex(S_INST1, 32'd0, "rst_inst1");
        @(posedge clk); #1;

        // single pair write, visible next cycle
        step(2'b11, 2'b00, mk(32'h1C00_0000, 32'h0280_0421, 1'b0, 7'h00),
                           mk(32'h1C00_0004, 32'h0380_0842, 1'b0, 7'h00));
        ex(S_VALID, 32'd3, "fwft_valid");
        ex(S_PC0, 32'h1C00_0000, "fwft_pc0");
        ex(S_PC1, 32'h1C00_0004, "fwft_pc1");
        ex(S_INST1, 32'h0380_0842, "fwft_inst1");
        ex(S_COUNT, 32'd2, "fwft_count");

        // fill to full
        step(2'b11, 2'b00, mk(32'h1C00_0008, 32'h1111_0008, 1'b0, 7'h00),
                           mk(32'h1C00_000C, 32'h1111_000C, 1'b0, 7'h00));
        step(2'b11, 2'b00, mk(32'h1C00_0010, 32'h1111_0010, 1'b0, 7'h00),
                           mk(32'h1C00_0014, 32'h1111_0014, 1'b0, 7'h00));
        ex(S_COUNT, 32'd6, "fill6_count");
        ex(S_READY, 32'd1, "fill6_ready");
        step(2'b11, 2'b00, mk(32'h1C00_0018, 32'h1111_0018, 1'b0, 7'h00),
                           mk(32'h1C00_001C, 32'h1111_001C, 1'b1, 7'h03));
        ex(S_COUNT, 32'd8, "full_count");
        ex(S_READY, 32'd0, "full_ready");
        ex(S_VALID, 32'd3, "full_valid");
        step(2'b11, 2'b00, mk(32'hDEAD_0000, 32'hDEAD_DEAD, 1'b0, 7'h00),
                           mk(32'hDEAD_0004, 32'hDEAD_DEAD, 1'b0, 7'h00));
        ex(S_COUNT, 32'd8, "full_drop_count");
        ex(S_PC0, 32'h1C00_0000, "full_drop_pc0");
        ex(S_PC1, 32'h1C00_0004, "full_drop_pc1");

        step(2'b00, 2'b11, z, z); ex(S_COUNT, 32'd6, "drain6");
        step(2'b00, 2'b11, z, z); ex(S_COUNT, 32'd4, "drain4");
        step(2'b00, 2'b11, z, z); ex(S_COUNT, 32'd2, "drain2");
        step(2'b00, 2'b11, z, z); ex(S_COUNT, 32'd0, "drain0");
        ex(S_VALID, 32'd0, "drain_valid");

        // occupancy DEPTH-1 refuses a write
        step(2'b01, 2'b00, mk(32'h0000_0040, 32'h2222_0040, 1'b0, 7'h00), z);
        step(2'b11, 2'b00, mk(32'h0000_0044, 32'h2222_0044, 1'b0, 7'h00),
                           mk(32'h0000_0048, 32'h2222_0048, 1'b0, 7'h00));
        step(2'b11, 2'b00, mk(32'h0000_004C, 32'h2222_004C, 1'b0, 7'h00),
                           mk(32'h0000_0050, 32'h2222_0050, 1'b0, 7'h00));
        step(2'b11, 2'b00, mk(32'h0000_0054, 32'h2222_0054, 1'b0, 7'h00),
                           mk(32'h0000_0058, 32'h2222_0058, 1'b0, 7'h00));
        ex(S_COUNT, 32'd7, "cnt7_count");
        ex(S_READY, 32'd0, "cnt7_ready");
        ex(S_VALID, 32'd3, "cnt7_valid");
        step(2'b01, 2'b00, mk(32'h0000_0BAD, 32'h0000_0BAD, 1'b0, 7'h00), z);
        ex(S_COUNT, 32'd7, "cnt7_drop_count");
        ex(S_PC0, 32'h0000_0040, "cnt7_pc0");
        step(2'b00, 2'b11, z, z); ex(S_COUNT, 32'd5, "d5");
        step(2'b00, 2'b11, z, z); ex(S_COUNT, 32'd3, "d3");
        step(2'b00, 2'b11, z, z); ex(S_COUNT, 32'd1, "d1");
        ex(S_VALID, 32'd1, "d1_valid");
        step(2'b00, 2'b10, z, z);
        ex(S_COUNT, 32'd1, "acc10_count");
        ex(S_PC0, 32'h0000_0058, "acc10_pc0");
        step(2'b00, 2'b11, z, z);
        ex(S_COUNT, 32'd0, "acc11_one_valid_count");
        ex(S_VALID, 32'd0, "acc11_one_valid_valid");

        // rd_ptr = wr_ptr = 7: pair write straddles the wrap
        step(2'b11, 2'b00, mk(32'h0000_00A0, 32'h3333_00A0, 1'b0, 7'h00),
                           mk(32'h0000_00A4, 32'h3333_00A4, 1'b0, 7'h00));
        ex(S_COUNT, 32'd2, "wrap_count_a");
        ex(S_PC0, 32'h0000_00A0, "wrap_pc0_a");
        ex(S_PC1, 32'h0000_00A4, "wrap_pc1_a");
        step(2'b01, 2'b01, mk(32'h0000_00A8, 32'h3333_00A8, 1'b0, 7'h00), z);
        ex(S_COUNT, 32'd2, "wrap_count_b");
        ex(S_PC0, 32'h0000_00A4, "wrap_pc0_b");
        ex(S_PC1, 32'h0000_00A8, "wrap_pc1_b");
        step(2'b00, 2'b11, z, z);
        ex(S_COUNT, 32'd0, "wrap_drain");

        // exception flags and cause pass through
        step(2'b11, 2'b00, mk(32'h0000_0300, 32'h4444_0300, 1'b1, 7'h08),
                           mk(32'h0000_0304, 32'h4444_0304, 1'b0, 7'h00));
        ex(S_EXC0, 32'd1, "exc0");
        ex(S_CAUSE0, 32'h08, "cause0");
        ex(S_EXC1, 32'd0, "exc1");
        ex(S_INST0, 32'h4444_0300, "exc_inst0");
        step(2'b11, 2'b00, mk(32'h0000_0308, 32'h4444_0308, 1'b0, 7'h00),
                           mk(32'h0000_030C, 32'h4444_030C, 1'b0, 7'h00));
        step(2'b01, 2'b00, mk(32'h0000_0310, 32'h4444_0310, 1'b0, 7'h00), z);
        ex(S_COUNT, 32'd5, "preflush_count");

        // flush beats same-cycle write and accept
        flush = 1'b1;
        fetch_valid = 2'b11;
        dec_accept = 2'b11;
        fetch_pc0 = 32'h0000_0400; fetch_pc1 = 32'h0000_0404;
        ex(S_READY, 32'd0, "flush_ready_low");
        @(posedge clk); #1;
        flush = 1'b0;
        fetch_valid = 2'b00;
        dec_accept = 2'b00;
        mq.delete();
        mcnt = 0;
        ex(S_COUNT, 32'd0, "flush_count");
        ex(S_VALID, 32'd0, "flush_valid");
        ex(S_READY, 32'd1, "flush_ready");
        step(2'b01, 2'b00, mk(32'h0000_0200, 32'h5555_0200, 1'b0, 7'h00), z);
        ex(S_PC0, 32'h0000_0200, "postflush_pc0");
        ex(S_COUNT, 32'd1, "postflush_count");
        ex(S_VALID, 32'd1, "postflush_valid");
        step(2'b00, 2'b01, z, z);
        ex(S_COUNT, 32'd0, "postflush_drain");

        // reset in the middle of operation
        step(2'b11, 2'b00, mk(32'h0000_0500, 32'h6666_0500, 1'b0, 7'h00),
                           mk(32'h0000_0504, 32'h6666_0504, 1'b0, 7'h00));
        ex(S_COUNT, 32'd2, "premid_count");
        @(posedge clk); #1;
        rst_n = 1'b0;
        mq.delete();
        mcnt = 0;
        ex(S_COUNT, 32'd0, "midrst_count");
        ex(S_VALID, 32'd0, "midrst_valid");
        ex(S_PC0, 32'd0, "midrst_pc0");
        ex(S_PC1, 32'd0, "midrst_pc1");
        ex(S_READY, 32'd1, "midrst_ready");
        @(posedge clk); #1;
        rst_n = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (cq.size() != 0) begin
            n_bad++;
            $display("FAIL pending_checks: got %0d left expected 0", cq.size());
        end
        n_cmp++;
        if (mq.size() != 0) begin
            n_bad++;
            $display("FAIL unconsumed_entries: got %0d left expected 0", mq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
